twowire_apb_arbiter: RTL



---
 rtl/twowire_apb_arbiter_pkg.sv | 16 +
 rtl/twowire_rr_pick.sv | 27 ++
 rtl/twowire_apb_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/twowire_apb_arbiter_pkg.sv
// Shared definitions for the APB3 master arbiter: state encodings and bus widths.
package twowire_apb_arbiter_pkg;

    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/twowire_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning upward from ptr+1.
module twowire_rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [IW-1:0] cand;

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/twowire_apb_arbiter.sv
// Round-robin arbiter sharing one downstream APB3 slave between N_MASTERS upstream masters,
// with a watchdog that forces an error completion when the slave never becomes ready.
//
//   state    | meaning
//   S_IDLE   | no transfer; pick next requester and capture its command
//   S_SETUP  | downstream psel=1, penable=0 with captured command
//   S_ACCESS | downstream psel=1, penable=1; wait for pready or watchdog
module twowire_apb_arbiter
    import twowire_apb_arbiter_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int W_ADDR    = 8,
    parameter int TIMEOUT   = 255,
    localparam int IW       = idx_width(N_MASTERS)
) (
    input  logic                          dck,
    input  logic                          drst,
    input  logic [N_MASTERS-1:0]          up_psel,
    input  logic [N_MASTERS-1:0]          up_penable,
    input  logic [N_MASTERS-1:0]          up_pwrite,
    input  logic [N_MASTERS*W_ADDR-1:0]   up_paddr,
    input  logic [N_MASTERS*32-1:0]       up_pwdata,
    output logic [N_MASTERS-1:0]          up_pready,
    output logic [N_MASTERS-1:0]          up_pslverr,
    output logic [APB_DATA_W-1:0]         up_prdata,
    output logic                          dst_psel,
    output logic                          dst_penable,
    output logic                          dst_pwrite,
    output logic [W_ADDR-1:0]             dst_paddr,
    output logic [APB_DATA_W-1:0]         dst_pwdata,
    input  logic                          dst_pready,
    input  logic                          dst_pslverr,
    input  logic [APB_DATA_W-1:0]         dst_prdata,
    output logic [IW-1:0]                 grant_idx,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam int WD_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_t state, state_nxt;

    logic [IW-1:0]         ptr;
    logic [IW-1:0]         pick_idx;
    logic                  pick_valid;
    logic [W_ADDR-1:0]     sel_addr, cap_addr;
    logic [APB_DATA_W-1:0] sel_wdata, cap_wdata;
    logic                  sel_write, cap_write;
    logic [WD_W-1:0]       wd_cnt;
    logic                  wd_hit;
    logic                  xfer_done;

    // Commands are captured from psel alone; upstream penable carries no extra information here.
    logic unused_penable;
    assign unused_penable = ^up_penable;

    twowire_rr_pick #(.N(N_MASTERS), .IW(IW)) u_pick (
        .req   (up_psel),
        .ptr   (ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (pick_idx == IW'(i)) begin
                sel_addr  = up_paddr[i*W_ADDR +: W_ADDR];
                sel_wdata = up_pwdata[i*32 +: 32];
                sel_write = up_pwrite[i];
            end
        end
    end

    // pready from the slave wins over the watchdog on the terminal cycle.
    assign wd_hit    = (TIMEOUT > 0) && (state == S_ACCESS) && !dst_pready && (wd_cnt == WD_LAST);
    assign xfer_done = (state == S_ACCESS) && (dst_pready || wd_hit);

    always_ff @(posedge dck) begin
        if (drst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (pick_valid) state_nxt = S_SETUP;
            S_SETUP:  state_nxt = S_ACCESS;
            S_ACCESS: if (xfer_done) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge dck) begin
        if (drst) begin
            grant_idx <= '0;
            ptr       <= IW'(N_MASTERS - 1);
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_write <= 1'b0;
            wd_cnt    <= '0;
        end else begin
            if (state == S_IDLE && pick_valid) begin
                grant_idx <= pick_idx;
                cap_addr  <= sel_addr;
                cap_wdata <= sel_wdata;
                cap_write <= sel_write;
                wd_cnt    <= '0;
            end
            if (state == S_SETUP)
                ptr <= grant_idx;
            if (state == S_ACCESS && !xfer_done)
                wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    assign busy        = (state != S_IDLE);
    assign dst_psel    = busy;
    assign dst_penable = (state == S_ACCESS);
    assign dst_pwrite  = busy ? cap_write : 1'b0;
    assign dst_paddr   = busy ? cap_addr  : '0;
    assign dst_pwdata  = busy ? cap_wdata : '0;
    assign timeout_err = wd_hit;
    assign up_prdata   = (state == S_ACCESS && dst_pready) ? dst_prdata : '0;

    always_comb begin
        up_pready  = '0;
        up_pslverr = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (xfer_done && grant_idx == IW'(i)) begin
                up_pready[i]  = 1'b1;
                up_pslverr[i] = dst_pready ? dst_pslverr : 1'b1;
            end
        end
    end

endmodule
